// File: rtl/rrat.sv
// rrat: retirement rename table for the 3-way R10K core.
// Holds the committed ARN->PRN map and the committed free bitmap, releases
// superseded PRNs to the free list and runs the mispredict recovery strobe.
// Optional build macro: RRAT_CHECK_EN adds a sticky consistency checker
// driving rrat_error_out; without it rrat_error_out is tied low.
//
// Handshake: lane k retires only when retire_valid_in[k], retire_dest_valid_in[k]
// and retire_ready_out are all high in the same cycle; retire_ready_out is high
// exactly while the FSM is in RUN, and inputs presented otherwise are dropped.
module rrat #(
   parameter int N_WAY          = 3,
   parameter int ARF_SIZE       = 32,
   parameter int ARF_WIDTH      = 5,
   parameter int PRF_SIZE       = 96,
   parameter int PRF_WIDTH      = 7,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [N_WAY-1:0]              retire_valid_in,
   input  logic [N_WAY-1:0]              retire_dest_valid_in,
   input  logic [N_WAY*ARF_WIDTH-1:0]    retire_dest_arn_in,
   input  logic [N_WAY*PRF_WIDTH-1:0]    retire_dest_prn_in,
   input  logic                          retire_mispredict_in,
   output logic                          retire_ready_out,
   output logic [ARF_SIZE*PRF_WIDTH-1:0] rrat_rename_table_out,
   output logic [PRF_SIZE-1:0]           committed_free_list_out,
   output logic [N_WAY*PRF_WIDTH-1:0]    free_prn_out,
   output logic [N_WAY-1:0]              free_prn_valid_out,
   output logic                          rat_mispredict_out,
   output logic                          rrat_error_out,
   output logic                          dbg_state_out
);

   localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } state_t;

   state_t                               r_state;
   state_t                               w_state_nxt;
   logic [CNT_W-1:0]                     r_cnt;
   logic [CNT_W-1:0]                     w_cnt_nxt;
   logic                                 r_mispredict;

   logic [ARF_SIZE-1:0][PRF_WIDTH-1:0]   r_table;
   logic [ARF_SIZE-1:0][PRF_WIDTH-1:0]   w_table_nxt;
   logic [PRF_SIZE-1:0]                  r_free;
   logic [PRF_SIZE-1:0]                  w_free_nxt;

   logic [N_WAY-1:0][ARF_WIDTH-1:0]      w_arn;
   logic [N_WAY-1:0][PRF_WIDTH-1:0]      w_prn;
   logic [N_WAY-1:0]                     w_eff;
   logic [N_WAY-1:0][PRF_WIDTH-1:0]      w_super;

   logic [N_WAY-1:0][PRF_WIDTH-1:0]      r_rel_prn;
   logic [N_WAY-1:0]                     r_rel_valid;
   logic [N_WAY-1:0][PRF_WIDTH-1:0]      w_rel_prn;
   logic [N_WAY-1:0]                     w_rel_valid;

   assign w_arn = retire_dest_arn_in;
   assign w_prn = retire_dest_prn_in;

   assign retire_ready_out        = (r_state == ST_RUN);
   assign rat_mispredict_out      = r_mispredict;
   assign rrat_rename_table_out   = r_table;
   assign committed_free_list_out = r_free;
   assign free_prn_out            = r_rel_prn;
   assign free_prn_valid_out      = r_rel_valid;
   assign dbg_state_out           = r_state;

   // Effective lanes: only destination-writing lanes accepted while in RUN.
   always_comb begin
      w_eff = retire_valid_in & retire_dest_valid_in & {N_WAY{retire_ready_out}};
   end

   // Superseded PRN: nearest older effective lane with same ARN, else committed map.
   always_comb begin
      w_super = '0;
      for (int k = 0; k < N_WAY; k++) begin
         w_super[k] = r_table[w_arn[k]];
         for (int j = 0; j < k; j++) begin
            if (w_eff[j] && (w_arn[j] == w_arn[k])) begin
               w_super[k] = w_prn[j];
            end
         end
      end
   end

   // Next map (youngest lane wins), next bitmap (set after clear) and releases.
   always_comb begin
      w_table_nxt = r_table;
      w_free_nxt  = r_free;
      w_rel_prn   = '0;
      w_rel_valid = '0;
      for (int k = 0; k < N_WAY; k++) begin
         if (w_eff[k]) begin
            w_table_nxt[w_arn[k]] = w_prn[k];
            w_free_nxt[w_prn[k]]  = 1'b0;
         end
      end
      for (int k = 0; k < N_WAY; k++) begin
         if (w_eff[k] && (w_super[k] != '0)) begin
            w_free_nxt[w_super[k]] = 1'b1;
            w_rel_prn[k]           = w_super[k];
            w_rel_valid[k]         = 1'b1;
         end
      end
   end

   // Committed map, bitmap and release registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_table     <= '0;
         r_free      <= {{(PRF_SIZE-1){1'b1}}, 1'b0};
         r_rel_prn   <= '0;
         r_rel_valid <= '0;
      end else begin
         r_table     <= w_table_nxt;
         r_free      <= w_free_nxt;
         r_rel_prn   <= w_rel_prn;
         r_rel_valid <= w_rel_valid;
      end
   end

   // Recovery FSM next state: a mispredict bundle enters RECOVER, counter runs down to 0.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (retire_mispredict_in) begin
               w_state_nxt = ST_RECOVER;
               w_cnt_nxt   = CNT_W'(RECOVER_CYCLES - 1);
            end
         end
         ST_RECOVER: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // FSM state register; the strobe is registered from the next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_RUN;
         r_cnt        <= '0;
         r_mispredict <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_mispredict <= (w_state_nxt == ST_RECOVER);
      end
   end

`ifdef RRAT_CHECK_EN
   logic w_err_hit;
   logic r_error;

   // Flag committing a PRN already marked free, or a nonzero PRN used twice in a bundle.
   always_comb begin
      w_err_hit = 1'b0;
      for (int k = 0; k < N_WAY; k++) begin
         if (w_eff[k]) begin
            if (r_free[w_prn[k]]) begin
               w_err_hit = 1'b1;
            end
            for (int j = 0; j < k; j++) begin
               if (w_eff[j] && (w_prn[j] == w_prn[k]) && (w_prn[k] != '0)) begin
                  w_err_hit = 1'b1;
               end
            end
         end
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_error <= 1'b0;
      end else begin
         r_error <= r_error | w_err_hit;
      end
   end

   assign rrat_error_out = r_error;
`else
   assign rrat_error_out = 1'b0;
`endif

endmodule
